alu_req_drv: RTL and testbench

- Hardware initiator for the driver-side ALU port. Takes operation requests on a valid/ready stream, drives alu_op/alu_a/alu_b into the sequential ALU wrapper, and tracks the fixed ALU latency.
- Captures alu_res into a response FIFO and returns it on a valid/ready stream.
- Lets RTL masters (sequencers, BIST) use the ALU without knowing its timing. The ALU cannot stall, so backpressure is handled with credits.

---
 rtl/alu_req_drv.sv | 189 ++++++++++++++++++
 tb/tb_alu_req_drv.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_drv.sv
// Request/response initiator for a fixed-latency sequential ALU, with credit-based flow control.
// Optional build macro ALU_REQ_DRV_PERF_EN adds saturating perf counters (perf_issued/perf_done/perf_stall).

package alu_req_drv_pkg;
    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_SLL   = 3'd5,
        ALU_SRL   = 3'd6,
        ALU_PASSB = 3'd7
    } alu_op_t;
endpackage

module alu_req_drv
    import alu_req_drv_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int ALU_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  alu_op_t           req_op,
    input  logic [DWIDTH-1:0] req_a,
    input  logic [DWIDTH-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_res,
    output alu_op_t           alu_op,
    output logic [DWIDTH-1:0] alu_a,
    output logic [DWIDTH-1:0] alu_b,
    input  logic [DWIDTH-1:0] alu_res,
    output logic              busy
`ifdef ALU_REQ_DRV_PERF_EN
    ,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_done,
    output logic [31:0]       perf_stall
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    alu_op_t           alu_op_q, alu_op_d;
    logic [DWIDTH-1:0] alu_a_q, alu_a_d;
    logic [DWIDTH-1:0] alu_b_q, alu_b_d;
    logic [ALU_LAT-1:0] vld_q, vld_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DWIDTH-1:0] mem_d [FIFO_DEPTH];

    logic          accept;
    logic          capture;
    logic          pop;
    logic [CW:0]   outstanding;

    // Credits count both results still inside the ALU and results already buffered,
    // so every accepted request is guaranteed a FIFO slot when it emerges.
    assign outstanding = {1'b0, inflight_q} + {1'b0, count_q};
    assign req_ready   = (outstanding < (CW+1)'(FIFO_DEPTH));
    assign busy        = (outstanding != '0);
    assign rsp_valid   = (count_q != '0);
    assign rsp_res     = mem_q[rd_ptr_q];
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;

    assign accept  = req_valid && req_ready;
    assign capture = vld_q[ALU_LAT-1];
    assign pop     = rsp_valid && rsp_ready;

    always_comb begin
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        if (accept) begin
            alu_op_d = req_op;
            alu_a_d  = req_a;
            alu_b_d  = req_b;
        end

        vld_d    = '0;
        vld_d[0] = accept;
        for (int i = 1; i < ALU_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        inflight_d = inflight_q;
        case ({accept, capture})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        count_d = count_q;
        case ({capture, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (capture) begin
            mem_d[wr_ptr_q] = alu_res;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q   <= alu_op_t'(0);
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            vld_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && !pop && count_q == CW'(FIFO_DEPTH)));

`ifdef ALU_REQ_DRV_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_done_q, perf_done_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_done_d   = perf_done_q;
        perf_stall_d  = perf_stall_q;
        if (accept && perf_issued_q != 32'hFFFF_FFFF) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if (pop && perf_done_q != 32'hFFFF_FFFF) begin
            perf_done_d = perf_done_q + 32'd1;
        end
        if (req_valid && !req_ready && perf_stall_q != 32'hFFFF_FFFF) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_done_q   <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_done_q   <= perf_done_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_done   = perf_done_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_req_drv.sv
// Randomized bench for alu_req_drv: transaction-level scoreboard plus a fixed-latency ALU model.
// Define ALU_REQ_DRV_PERF_EN for both files to also check the perf counters.

module tb_alu_req_drv;
    import alu_req_drv_pkg::*;

    localparam int DWIDTH     = 32;
    localparam int ALU_LAT    = 1;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        int unsigned       rdy_cyc;
        logic [DWIDTH-1:0] res;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    alu_op_t           req_op = ALU_ADD;
    logic [DWIDTH-1:0] req_a = '0;
    logic [DWIDTH-1:0] req_b = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DWIDTH-1:0] rsp_res;
    alu_op_t           alu_op;
    logic [DWIDTH-1:0] alu_a;
    logic [DWIDTH-1:0] alu_b;
    logic [DWIDTH-1:0] alu_res;
    logic              busy;
`ifdef ALU_REQ_DRV_PERF_EN
    logic [31:0]       perf_issued;
    logic [31:0]       perf_done;
    logic [31:0]       perf_stall;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    exp_t              exp_q[$];
    int unsigned       cyc = 0;
    alu_op_t           last_op = ALU_ADD;
    logic [DWIDTH-1:0] last_a = '0;
    logic [DWIDTH-1:0] last_b = '0;
    logic [31:0]       m_issued = '0;
    logic [31:0]       m_done = '0;
    logic [31:0]       m_stall = '0;
    int                dut_acc;

    always #5 clk = ~clk;

    alu_req_drv #(
        .DWIDTH    (DWIDTH),
        .ALU_LAT   (ALU_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_res    (alu_res),
        .busy       (busy)
`ifdef ALU_REQ_DRV_PERF_EN
        ,
        .perf_issued(perf_issued),
        .perf_done  (perf_done),
        .perf_stall (perf_stall)
`endif
    );

    function automatic logic [DWIDTH-1:0] alu_fn(alu_op_t op, logic [DWIDTH-1:0] a, logic [DWIDTH-1:0] b);
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << b[4:0];
            ALU_SRL:   return a >> b[4:0];
            ALU_PASSB: return b;
            default:   return '0;
        endcase
    endfunction

    // The ALU wrapper: result of the currently driven operands appears ALU_LAT edges later.
    generate
        if (ALU_LAT == 1) begin : g_alu_comb
            assign alu_res = alu_fn(alu_op, alu_a, alu_b);
        end else begin : g_alu_pipe
            logic [DWIDTH-1:0] pipe [ALU_LAT-1];
            always @(posedge clk) begin
                pipe[0] <= alu_fn(alu_op, alu_a, alu_b);
                for (int i = 1; i < ALU_LAT - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
            assign alu_res = pipe[ALU_LAT-2];
        end
    endgenerate

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs against the scoreboard, drive inputs, advance the model.
    task automatic applyStimulus(input logic v, input alu_op_t op, input logic [DWIDTH-1:0] a,
                                 input logic [DWIDTH-1:0] b, input logic rr);
        logic exp_ready;
        logic exp_rvalid;
        @(negedge clk);
        exp_ready  = (exp_q.size() < FIFO_DEPTH);
        exp_rvalid = (exp_q.size() != 0) && (exp_q[0].rdy_cyc <= cyc);
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_rvalid));
        checkOutput("busy", 64'(busy), 64'(exp_q.size() != 0));
        if (exp_rvalid) begin
            checkOutput("rsp_res", 64'(rsp_res), 64'(exp_q[0].res));
        end
        checkOutput("alu_op", 64'(alu_op), 64'(last_op));
        checkOutput("alu_a", 64'(alu_a), 64'(last_a));
        checkOutput("alu_b", 64'(alu_b), 64'(last_b));
`ifdef ALU_REQ_DRV_PERF_EN
        checkOutput("perf_issued", 64'(perf_issued), 64'(m_issued));
        checkOutput("perf_done", 64'(perf_done), 64'(m_done));
        checkOutput("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
        if (v && req_ready) dut_acc++;

        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;

        if (exp_rvalid && rr) begin
            void'(exp_q.pop_front());
            if (m_done != 32'hFFFF_FFFF) m_done++;
        end
        if (v && exp_ready) begin
            exp_q.push_back('{cyc + ALU_LAT + 1, alu_fn(op, a, b)});
            last_op = op;
            last_a  = a;
            last_b  = b;
            if (m_issued != 32'hFFFF_FFFF) m_issued++;
        end
        if (v && !exp_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        cyc++;
    endtask

    task automatic doReset(input int ncyc);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_q.delete();
        last_op  = ALU_ADD;
        last_a   = '0;
        last_b   = '0;
        m_issued = '0;
        m_done   = '0;
        m_stall  = '0;
        #1;
        checkOutput("rst_req_ready", 64'(req_ready), 64'(1));
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_alu_a", 64'(alu_a), 64'(0));
        checkOutput("rst_alu_b", 64'(alu_b), 64'(0));
        repeat (ncyc) @(negedge clk);
        rst_n = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) applyStimulus(1'b0, ALU_ADD, '0, '0, rr);
    endtask

    initial begin
        int stall_seen;
        $display("[TB] start: DWIDTH=%0d ALU_LAT=%0d FIFO_DEPTH=%0d", DWIDTH, ALU_LAT, FIFO_DEPTH);

        doReset(2);
        idle(2, 1'b0);

        applyStimulus(1'b1, ALU_ADD, 32'd5, 32'd7, 1'b1);
        idle(4, 1'b1);

        dut_acc = 0;
        m_stall = '0;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, ALU_ADD, DWIDTH'(i), '0, 1'b0);
        end
        stall_seen = int'(m_stall);
        checkOutput("fill_accepted", 64'(dut_acc), 64'(4));
        idle(1, 1'b0);
        checkOutput("fill_ready_low", 64'(req_ready), 64'(0));
`ifdef ALU_REQ_DRV_PERF_EN
        checkOutput("perf_issued_pre", 64'(perf_issued), 64'(5));
        checkOutput("perf_stall_meas", 64'(perf_stall), 64'(stall_seen));
`endif
        idle(8, 1'b1);
        checkOutput("drain_ready", 64'(req_ready), 64'(1));
`ifdef ALU_REQ_DRV_PERF_EN
        checkOutput("perf_done_post", 64'(perf_done), 64'(5));
`endif

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, ALU_ADD, DWIDTH'(i), DWIDTH'(i), 1'b1);
        end
        idle(4, 1'b1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, ALU_SUB, DWIDTH'($urandom), DWIDTH'($urandom), 1'b0);
        end
        doReset(1);
        idle(6, 1'b1);

        // Random traffic with varying request and response pressure.
        for (int phase = 0; phase < 8; phase++) begin
            int pv = $urandom_range(20, 100);
            int pr = $urandom_range(10, 100);
            for (int i = 0; i < 250; i++) begin
                applyStimulus(($urandom_range(0, 99) < pv) ? 1'b1 : 1'b0,
                              alu_op_t'(3'($urandom_range(0, 7))),
                              DWIDTH'($urandom), DWIDTH'($urandom),
                              ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0);
            end
            if (phase == 4) begin
                doReset(1);
            end
        end
        idle(12, 1'b1);
        checkOutput("final_busy", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
